// File: rtl/uart_tx_block.sv
// uart_tx_block: UART transmitter.
// Each frame is a start bit, N data bits sent LSB first, an optional even-parity
// bit and NUM_STOP stop bits, and every serial bit lasts BP = max(bit_period,1)
// clock cycles. tx_data, data_size and bit_period are captured when a request
// is accepted, so the frame in flight ignores any later change to them.
// A request made in the tx_done cycle starts the next frame with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN adds a PARITY state after DATA.
module uart_tx_block #(
    parameter int NUM_STOP = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  tx_data,
    input  logic [3:0]  data_size,
    input  logic [13:0] bit_period,
    input  logic        tx_start,
    output logic        serial_out,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, nxt;
    logic [13:0] cnt;       // 1..BP within the current serial bit
    logic [13:0] bp_q;      // latched BP, never 0
    logic [3:0]  n_q;       // latched effective data size
    logic [2:0]  bidx;      // data bit index 0..N-1
    logic        sidx;      // stop bit index 0..NUM_STOP-1
    logic [7:0]  sh;        // data shift register, LSB on the line
    logic        ovr_q;
    logic        ser;
    logic        done;
    logic        accept;
    logic        bit_end;
    logic        last_bit;
    logic        stop_end;
    logic [3:0]  n_eff;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
    logic [7:0]  mask;
`endif

    // Decode the requested data size; anything outside 5/7/8 sends 8 bits.
    always_comb begin
        n_eff = 4'd8;
`ifdef UART_TX_PARITY_EN
        mask  = 8'hFF;
`endif
        case (data_size)
            4'd5: begin
                n_eff = 4'd5;
`ifdef UART_TX_PARITY_EN
                mask  = 8'h1F;
`endif
            end
            4'd7: begin
                n_eff = 4'd7;
`ifdef UART_TX_PARITY_EN
                mask  = 8'h7F;
`endif
            end
            default: ;
        endcase
    end

    assign bit_end  = (cnt == bp_q);
    assign last_bit = (bidx == 3'(n_q - 4'd1));
    assign stop_end = bit_end && (sidx == 1'(NUM_STOP - 1));
    // A request in the tx_done cycle is accepted, never rejected.
    assign accept   = tx_start && ((state == IDLE) || done);

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= nxt;
    end

    // Next state plus the line level and done strobe of the current state.
    always_comb begin
        nxt  = state;
        ser  = 1'b1;
        done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) nxt = START;
            end
            START: begin
                ser = 1'b0;
                if (bit_end) nxt = DATA;
            end
            DATA: begin
                ser = sh[0];
`ifdef UART_TX_PARITY_EN
                if (bit_end && last_bit) nxt = PARITY;
`else
                if (bit_end && last_bit) nxt = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                ser = par_q;
                if (bit_end) nxt = STOP;
            end
`endif
            STOP: begin
                if (stop_end) begin
                    done = 1'b1;
                    nxt  = tx_start ? START : IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Frame datapath: capture on acceptance, then step bit timing and shifting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt   <= '0;
            bp_q  <= '0;
            n_q   <= '0;
            bidx  <= '0;
            sidx  <= 1'b0;
            sh    <= '0;
            ovr_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            ovr_q <= tx_start && (state != IDLE) && !done;
            if (accept) begin
                cnt  <= 14'd1;
                bp_q <= (bit_period == 14'd0) ? 14'd1 : bit_period;
                n_q  <= n_eff;
                bidx <= '0;
                sidx <= 1'b0;
                sh   <= tx_data;
`ifdef UART_TX_PARITY_EN
                par_q <= ^(tx_data & mask);
`endif
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (bit_end) begin
                cnt <= 14'd1;
                if (state == DATA) begin
                    sh   <= sh >> 1;
                    bidx <= bidx + 3'd1;
                end
                if (state == STOP) sidx <= sidx + 1'b1;
            end else begin
                cnt <= cnt + 14'd1;
            end
        end
    end

    assign serial_out = ser;
    assign tx_busy    = (state != IDLE);
    assign tx_done    = done;
    assign tx_overrun = ovr_q;

endmodule

// File: doc/uart_tx_block.md
Name: uart_tx_block

Overview:
- Serial UART transmitter. It is the transmit-direction counterpart of the team's receiver block (rcv_block).
- Frames parallel data with a start bit, data bits sent LSB first, optional parity, and stop bit(s). Drives a single idle-high serial line.
- Runtime configuration (data_size, bit_period) uses the same encoding as the receiver's APB register map, so one APB slave can configure both directions.

Parameters:
- NUM_STOP, 1: number of stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- tx_data  input  8  data to send; bits [N-1:0] are used, where N is the effective data size
- data_size  input  4  data bits per frame; 5, 7 and 8 are legal, any other value gives N=8
- bit_period  input  14  clk cycles per serial bit; 0 is treated as 1
- tx_start  input  1  transmit request, sampled on every clk edge
- serial_out  output  1  serial line, idle high
- tx_busy  output  1  high for every cycle of an active frame
- tx_done  output  1  one-cycle pulse in the last cycle of a frame
- tx_overrun  output  1  one-cycle pulse when a tx_start is rejected

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous and active-low.
  - Reset values: serial_out=1, tx_busy=0, tx_done=0, tx_overrun=0, FSM=IDLE, all counters 0.
  - Reset asserted mid-frame drives serial_out high immediately, without waiting for clk, and abandons the frame.
- Acceptance:
  - tx_start is accepted on a clk edge when (tx_busy==0 || tx_done==1).
  - At acceptance, tx_data, data_size and bit_period are latched. Later changes to these inputs do not affect the frame in flight.
- Rejection:
  - tx_start with tx_busy==1 and tx_done==0 is ignored.
  - tx_overrun pulses high for one cycle, the cycle after the rejected request.
  - The frame in flight is unaffected.
- FSM states: IDLE, START, DATA, PARITY (present only with the optional feature), STOP.
  - IDLE -> START on acceptance. From the next cycle: serial_out=0, tx_busy=1. Latency from the accepting edge to the falling start edge is 1 cycle.
  - Bit timing: a 14-bit counter counts 1..BP, where BP = max(bit_period,1). Each serial bit is held for exactly BP cycles, and the state or bit advances when the counter reaches BP.
  - START -> DATA after BP cycles.
  - DATA: a shift register outputs its LSB. A bit counter counts 0..N-1. After BP cycles of bit N-1 the FSM moves to PARITY if the feature is enabled, otherwise to STOP.
  - STOP: serial_out=1 for NUM_STOP*BP cycles. tx_done=1 during the final cycle of the stop period.
  - Leaving STOP: to IDLE (tx_busy=0, serial_out=1) if no tx_start is pending in the tx_done cycle. If tx_start is high in the tx_done cycle, the next frame is accepted and goes directly to START with no idle gap.
- Frame length: (1 + N + P + NUM_STOP) * BP cycles, where P=1 with parity enabled, otherwise 0. tx_busy is high for exactly those cycles.
- Boundary conditions:
  - BP=1 gives one cycle per bit, with continuous back-to-back frames possible.
  - bit_period=16383 must not overflow the bit counter.
  - Illegal data_size (for example 0, 6 or 15) gives N=8.
- Simultaneous events: acceptance in the tx_done cycle takes priority over returning to IDLE. tx_overrun is never raised in that cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- With the macro defined:
  - A PARITY state follows DATA and lasts BP cycles.
  - serial_out = even parity (XOR) of the N transmitted data bits.
  - Frame length includes P=1.
- Without the macro: no PARITY state, P=0, and the frame goes directly from DATA to STOP.

Test Plan:
1. Reset; NUM_STOP=1; bit_period=10, data_size=8, tx_data=8'hA5; pulse tx_start -> serial_out holds each of 0,1,0,1,0,0,1,0,1,1 for 10 cycles; tx_busy high for 100 cycles; tx_done pulses in cycle 100.
2. data_size=5, tx_data=8'hF3, bit_period=4 -> bits 0,1,1,0,0,1,1 (start, then 5'b10011 LSB first, then stop), frame 28 cycles; repeat with data_size=6 -> 8-bit frame of 40 cycles.
3. Hold tx_start high continuously with tx_data=8'h00 then 8'hFF, bit_period=1 -> second start bit in the cycle right after the first tx_done; no idle-high cycle between frames.
4. tx_start mid-frame (cycle 30 of the test-1 frame) -> tx_overrun single pulse; serial_out waveform identical to test 1; no second frame.
5. Change bit_period to 2 and tx_data to 8'h00 mid-frame, then assert n_rst=0 at cycle 45 -> the frame continues at BP=10 with the original data until reset; serial_out=1 and tx_busy=0 asynchronously at reset; a new tx_start after release produces a clean frame.
6. With UART_TX_PARITY_EN defined: tx_data=8'h07, data_size=8, bit_period=3 -> parity bit 1 after data, frame 33 cycles; with tx_data=8'h03 -> parity bit 0.
